// File: rtl/bp_gshare_multi_pkg.sv
// Shared types for the multi-lane branch predictor: mode select, ROB result record, B-type immediate decode.
package bp_gshare_multi_pkg;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    localparam int BP_RES_GHR_W = 10;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    taken;
        logic [BP_RES_GHR_W-1:0] ghr;
        logic                    mispredict;
    } bp_res_t;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Saturating counter array: NUM_RD combinational MSB read ports, one synchronous training port.
module bp_counter_table #(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 1024,
    parameter int CW     = 2,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*IW-1:0] rd_idx,
    output logic [NUM_RD-1:0]    rd_msb,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic                 wr_taken
);
    localparam logic [CW-1:0] CTR_INIT = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] CTR_MAX  = '1;

    logic [CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= CTR_INIT;
            end
        end else if (wr_en) begin
            if (wr_taken && mem[wr_idx] != CTR_MAX) begin
                mem[wr_idx] <= mem[wr_idx] + 1'b1;
            end else if (!wr_taken && mem[wr_idx] != '0) begin
                mem[wr_idx] <= mem[wr_idx] - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_msb[i] = mem[rd_idx[i*IW +: IW]][CW-1];
    end

endmodule

// File: rtl/bp_gshare_multi.sv
// Multi-lane bimodal/gshare conditional branch predictor with speculative GHR, per-lane snapshots and perf counters.
module bp_gshare_multi
    import bp_gshare_multi_pkg::*;
#(
    parameter int       NUM_LANES   = 2,
    parameter int       CTABLE_SIZE = 1024,
    parameter int       COUNTER_LEN = 2,
    parameter int       GHR_LEN     = 10,
    parameter bp_mode_e MODE        = BP_GSHARE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_fire_i,
    input  logic [NUM_LANES*32-1:0]      fetch_pc_i,
    input  logic [NUM_LANES*32-1:0]      fetch_instr_i,
    input  logic [NUM_LANES-1:0]         fetch_is_br_i,
    output logic [NUM_LANES-1:0]         pred_taken_o,
    output logic [NUM_LANES*32-1:0]      pred_addr_o,
    output logic [NUM_LANES*GHR_LEN-1:0] pred_ghr_o,
    input  logic                         res_valid_i,
    input  logic [31:0]                  res_pc_i,
    input  logic                         res_taken_i,
    input  logic [GHR_LEN-1:0]           res_ghr_i,
    input  logic                         res_mispredict_i,
    output logic [31:0]                  perf_resolved_o,
    output logic [31:0]                  perf_mispred_o
);
    localparam int IDX_W = $clog2(CTABLE_SIZE);

    logic [GHR_LEN-1:0]         spec_ghr;
    logic [GHR_LEN-1:0]         ghr_fetch;
    logic [GHR_LEN-1:0]         snap [NUM_LANES];
    logic [NUM_LANES*IDX_W-1:0] rd_idx;
    logic [NUM_LANES-1:0]       rd_msb;
    logic [NUM_LANES-1:0]       taken;
    logic                       recover;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc, input logic [GHR_LEN-1:0] h);
        logic [IDX_W-1:0] hx;
        hx = (MODE == BP_GSHARE) ? IDX_W'(h) : '0;
        return pc[2 +: IDX_W] ^ hx;
    endfunction

    // Snapshots depend only on branch positions, not on predictions, so they can feed the table reads.
    always_comb begin
        logic [GHR_LEN-1:0] run;
        run    = spec_ghr;
        rd_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            snap[i] = run;
            rd_idx[i*IDX_W +: IDX_W] = idx_of(fetch_pc_i[i*32 +: 32], run);
            if (fetch_is_br_i[i]) begin
                run = run << 1;
            end
        end
    end

    always_comb begin
        logic killed;
        killed    = 1'b0;
        taken     = '0;
        ghr_fetch = spec_ghr;
        for (int i = 0; i < NUM_LANES; i++) begin
            taken[i] = fetch_is_br_i[i] & rd_msb[i] & ~killed;
            if (fetch_is_br_i[i] && !killed) begin
                ghr_fetch = {ghr_fetch[GHR_LEN-2:0], taken[i]};
            end
            killed = killed | taken[i];
        end
    end

    assign pred_taken_o = taken;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign pred_addr_o[i*32 +: 32] = taken[i]
            ? fetch_pc_i[i*32 +: 32] + imm_b(fetch_instr_i[i*32 +: 32])
            : fetch_pc_i[i*32 +: 32] + 32'd4;
        assign pred_ghr_o[i*GHR_LEN +: GHR_LEN] = snap[i];
    end

    bp_counter_table #(
        .NUM_RD (NUM_LANES),
        .DEPTH  (CTABLE_SIZE),
        .CW     (COUNTER_LEN),
        .IW     (IDX_W)
    ) u_ctable (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_msb   (rd_msb),
        .wr_en    (res_valid_i),
        .wr_idx   (idx_of(res_pc_i, res_ghr_i)),
        .wr_taken (res_taken_i)
    );

    assign recover = res_valid_i & res_mispredict_i;

    // Recovery wins over fetch: the group fetched alongside a mispredict is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr        <= '0;
            perf_resolved_o <= '0;
            perf_mispred_o  <= '0;
        end else begin
            if (recover) begin
                spec_ghr <= {res_ghr_i[GHR_LEN-2:0], res_taken_i};
            end else if (fetch_fire_i) begin
                spec_ghr <= ghr_fetch;
            end
            if (res_valid_i && perf_resolved_o != '1) begin
                perf_resolved_o <= perf_resolved_o + 32'd1;
            end
            if (recover && perf_mispred_o != '1) begin
                perf_mispred_o <= perf_mispred_o + 32'd1;
            end
        end
    end

endmodule
